// File: rtl/mux_sel_sequencer.sv
// Word-to-bit sequencer for the 8:1 bit-select mux: latches a word, then walks sel over all
// eight bits with a programmable hold per slot. Define MUX_SEL_PARITY_EN for a trailing parity slot.
module mux_sel_sequencer #(
   parameter bit          MSB_FIRST = 1'b0,
   parameter int unsigned HOLD      = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   input  logic       enable,
   output logic [7:0] word_out,
   output logic [2:0] sel,
   output logic       bit_valid,
   output logic       bit_strobe,
   output logic       bit_last,
`ifdef MUX_SEL_PARITY_EN
   output logic       parity_out,
`endif
   output logic [1:0] dbg_state_o
);

   // Handshake: a word is taken at a rising edge where data_valid && data_ready; data_valid
   // while data_ready is low is ignored, so the producer must keep it asserted until accepted.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1
`ifdef MUX_SEL_PARITY_EN
      ,PARITY = 2'd2
`endif
   } state_e;

   localparam logic [7:0] HOLD_M1   = 8'(HOLD - 1);
   localparam logic [2:0] START_SEL = MSB_FIRST ? 3'd7 : 3'd0;
   localparam logic [2:0] LAST_SEL  = MSB_FIRST ? 3'd0 : 3'd7;

   state_e     state_q;
   logic [7:0] word_q;
   logic [2:0] sel_q;
   logic [7:0] cnt_q;
   logic       bit_valid_q;
   logic       bit_last_q;
`ifdef MUX_SEL_PARITY_EN
   logic       parity_q;
`endif

   logic       slot_end_d;
   logic       accept_d;
   logic [2:0] sel_d;

   assign slot_end_d = (cnt_q == HOLD_M1);
   assign bit_strobe = slot_end_d & enable & bit_valid_q;
   // Ready on the final-slot strobe lets the next word follow with no idle cycle.
   assign data_ready = (state_q == IDLE) | (bit_strobe & bit_last_q);
   assign accept_d   = data_valid & data_ready;
   assign sel_d      = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         word_q      <= 8'd0;
         sel_q       <= 3'd0;
         cnt_q       <= 8'd0;
         bit_valid_q <= 1'b0;
         bit_last_q  <= 1'b0;
`ifdef MUX_SEL_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else if (accept_d) begin
         state_q     <= SHIFT;
         word_q      <= data_in;
         sel_q       <= START_SEL;
         cnt_q       <= 8'd0;
         bit_valid_q <= 1'b1;
         bit_last_q  <= 1'b0;
`ifdef MUX_SEL_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            SHIFT: begin
               if (enable) begin
                  if (slot_end_d) begin
                     cnt_q <= 8'd0;
                     if (sel_q == LAST_SEL) begin
`ifdef MUX_SEL_PARITY_EN
                        state_q    <= PARITY;
                        bit_last_q <= 1'b1;
                        parity_q   <= ^word_q;
`else
                        state_q     <= IDLE;
                        bit_valid_q <= 1'b0;
                        bit_last_q  <= 1'b0;
`endif
                     end else begin
                        sel_q <= sel_d;
`ifdef MUX_SEL_PARITY_EN
                        bit_last_q <= 1'b0;
`else
                        bit_last_q <= (sel_d == LAST_SEL);
`endif
                     end
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
            end
`ifdef MUX_SEL_PARITY_EN
            PARITY: begin
               // sel keeps its last data value for the whole parity slot.
               if (enable) begin
                  if (slot_end_d) begin
                     state_q     <= IDLE;
                     cnt_q       <= 8'd0;
                     bit_valid_q <= 1'b0;
                     bit_last_q  <= 1'b0;
                     parity_q    <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
            end
`endif
            default: begin
            end
         endcase
      end
   end

   assign word_out    = word_q;
   assign sel         = sel_q;
   assign bit_valid   = bit_valid_q;
   assign bit_last    = bit_last_q;
`ifdef MUX_SEL_PARITY_EN
   assign parity_out  = parity_q;
`endif
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: an LSB-first HOLD=1 instance and an MSB-first HOLD=3 instance,
// both checked every cycle against a slot/position model and a queue of expected serial bits.
module tb_mux_sel_sequencer;

`ifdef MUX_SEL_PARITY_EN
   localparam int NSLOT = 9;
`else
   localparam int NSLOT = 8;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din [2];
   logic       dv [2];
   logic       en [2];
   logic       dr [2];
   logic       bv [2];
   logic       bs [2];
   logic       bl [2];
   logic       par [2];
   logic [7:0] wo [2];
   logic [2:0] sl [2];
   logic [1:0] dbg [2];

   int         n_checks = 0;
   int         n_errors = 0;
   logic [0:0] exp_q[$];
   logic [7:0] send_q[$];

   bit         m_active;
   int         m_pos;
   logic [7:0] m_word;
   bit         exp_dr_r;
   bit         last_acc;

   always #5 clk = ~clk;

   mux_sel_sequencer #(.MSB_FIRST(1'b0), .HOLD(1)) u_lsb (
      .clk(clk), .rst_n(rst_n), .data_in(din[0]), .data_valid(dv[0]), .data_ready(dr[0]),
      .enable(en[0]), .word_out(wo[0]), .sel(sl[0]), .bit_valid(bv[0]), .bit_strobe(bs[0]),
      .bit_last(bl[0]),
`ifdef MUX_SEL_PARITY_EN
      .parity_out(par[0]),
`endif
      .dbg_state_o(dbg[0])
   );

   mux_sel_sequencer #(.MSB_FIRST(1'b1), .HOLD(3)) u_msb (
      .clk(clk), .rst_n(rst_n), .data_in(din[1]), .data_valid(dv[1]), .data_ready(dr[1]),
      .enable(en[1]), .word_out(wo[1]), .sel(sl[1]), .bit_valid(bv[1]), .bit_strobe(bs[1]),
      .bit_last(bl[1]),
`ifdef MUX_SEL_PARITY_EN
      .parity_out(par[1]),
`endif
      .dbg_state_o(dbg[1])
   );

`ifndef MUX_SEL_PARITY_EN
   assign par[0] = 1'b0;
   assign par[1] = 1'b0;
`endif

   function automatic int hold_of(input int idx);
      return (idx == 0) ? 1 : 3;
   endfunction

   function automatic bit msb_of(input int idx);
      return idx != 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset();
      for (int i = 0; i < 2; i++) begin
         chk("rst_sel", 32'(sl[i]), 0);
         chk("rst_word_out", 32'(wo[i]), 0);
         chk("rst_bit_valid", 32'(bv[i]), 0);
         chk("rst_bit_strobe", 32'(bs[i]), 0);
         chk("rst_bit_last", 32'(bl[i]), 0);
         chk("rst_data_ready", 32'(dr[i]), 1);
`ifdef MUX_SEL_PARITY_EN
         chk("rst_parity_out", 32'(par[i]), 0);
`endif
      end
   endtask

   // Expected outputs follow from how many enabled cycles have elapsed since the accept.
   task automatic check_cycle(input int idx);
      int         h;
      int         slot;
      logic [2:0] esel;
      bit         ebs;
      bit         ebl;
      bit         edr;
      logic [0:0] exp_bit;
      logic       obs_bit;
      logic [7:0] w;
      h    = hold_of(idx);
      slot = m_pos / h;
      if (slot > 7) esel = msb_of(idx) ? 3'd0 : 3'd7;
      else          esel = msb_of(idx) ? 3'(7 - slot) : 3'(slot);
      ebs = m_active && en[idx] && ((m_pos % h) == h - 1);
      ebl = m_active && (slot == NSLOT - 1);
      edr = !m_active || (ebs && ebl);
      chk("bit_valid", 32'(bv[idx]), 32'(m_active));
      chk("bit_strobe", 32'(bs[idx]), 32'(ebs));
      chk("bit_last", 32'(bl[idx]), 32'(ebl));
      chk("data_ready", 32'(dr[idx]), 32'(edr));
`ifdef MUX_SEL_PARITY_EN
      chk("parity_out", 32'(par[idx]), (m_active && slot == 8) ? 32'(^m_word) : 0);
`endif
      if (m_active) begin
         chk("sel", 32'(sl[idx]), 32'(esel));
         chk("word_out", 32'(wo[idx]), 32'(m_word));
      end
      if (ebs) begin
         chk("exp_q_nonempty", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            exp_bit = exp_q.pop_front();
            w       = wo[idx];
            obs_bit = (slot == 8) ? par[idx] : w[sl[idx]];
            chk("mux_bit", 32'(obs_bit), 32'(exp_bit));
         end
      end
      exp_dr_r = edr;
   endtask

   task automatic update(input int idx, input bit acc, input logic [7:0] d, input bit e);
      if (acc) begin
         m_active = 1'b1;
         m_pos    = 0;
         m_word   = d;
         for (int k = 0; k < 8; k++) exp_q.push_back(d[msb_of(idx) ? 7 - k : k]);
`ifdef MUX_SEL_PARITY_EN
         exp_q.push_back(^d);
`endif
      end else if (m_active && e) begin
         m_pos++;
         if (m_pos == NSLOT * hold_of(idx)) m_active = 1'b0;
      end
   endtask

   // Entered and left at a falling edge; inputs change here, outputs are checked 1 time unit later.
   task automatic cyc(input int idx, input bit v, input logic [7:0] d, input bit e);
      for (int i = 0; i < 2; i++) begin
         dv[i] = 1'b0;
         en[i] = 1'b0;
      end
      dv[idx]  = v;
      en[idx]  = e;
      din[idx] = d;
      #1;
      check_cycle(idx);
      last_acc = v && exp_dr_r;
      @(posedge clk);
      update(idx, last_acc, d, e);
      @(negedge clk);
   endtask

   task automatic drain(input int idx);
      int g = 0;
      while (m_active && g < 200) begin
         cyc(idx, 1'b0, 8'd0, 1'b1);
         g++;
      end
      chk("drain_done", 32'(m_active), 0);
   endtask

   task automatic stream(input int idx, input int ncyc, output int valid_cycles);
      valid_cycles = 0;
      for (int c = 0; c < ncyc; c++) begin
         if (send_q.size() > 0) cyc(idx, 1'b1, send_q[0], 1'b1);
         else                   cyc(idx, 1'b0, 8'd0, 1'b1);
         if (last_acc) void'(send_q.pop_front());
         if (bv[idx]) valid_cycles++;
      end
   endtask

   task automatic run_rand(input int idx, input int nwords);
      int         sent  = 0;
      int         guard = 0;
      bit         hold  = 1'b0;
      logic [7:0] w     = 8'd0;
      while (sent < nwords && guard < 4000) begin
         if (!hold && $urandom_range(0, 3) != 0) begin
            hold = 1'b1;
            w    = 8'($urandom);
         end
         cyc(idx, hold, w, $urandom_range(0, 3) != 0);
         if (last_acc) begin
            hold = 1'b0;
            sent++;
         end
         guard++;
      end
      chk("rand_words_sent", 32'(sent), 32'(nwords));
      drain(idx);
   endtask

   initial begin
      int vcyc;
      rst_n    = 1'b0;
      m_active = 1'b0;
      m_pos    = 0;
      m_word   = 8'd0;
      exp_dr_r = 1'b1;
      last_acc = 1'b0;
      for (int i = 0; i < 2; i++) begin
         din[i] = 8'd0;
         dv[i]  = 1'b0;
         en[i]  = 1'b0;
      end
      repeat (2) @(negedge clk);
      #1;
      chk_reset();
      rst_n = 1'b1;
      @(negedge clk);

      // LSB-first, HOLD=1, 8'hA5
      cyc(0, 1'b1, 8'hA5, 1'b1);
      repeat (NSLOT + 1) cyc(0, 1'b0, 8'd0, 1'b1);
      chk("basic_idle", 32'(bv[0]), 0);

      // MSB-first, HOLD=3, 8'h81
      cyc(1, 1'b1, 8'h81, 1'b1);
      repeat (NSLOT * 3 + 2) cyc(1, 1'b0, 8'd0, 1'b1);

      // Back-to-back 8'h0F then 8'hF0 with valid held
      send_q = '{8'h0F, 8'hF0};
      stream(0, 2 * NSLOT + 4, vcyc);
      chk("b2b_valid_cycles", 32'(vcyc), 32'(2 * NSLOT));
      chk("b2b_sent", 32'(send_q.size()), 0);

      // Stall at sel=3 (HOLD=1), then stall mid-slot on the HOLD=3 instance
      cyc(0, 1'b1, 8'h5A, 1'b1);
      repeat (3) cyc(0, 1'b0, 8'd0, 1'b1);
      repeat (5) cyc(0, 1'b0, 8'd0, 1'b0);
      drain(0);
      cyc(1, 1'b1, 8'hC6, 1'b1);
      repeat (4) cyc(1, 1'b0, 8'd0, 1'b1);
      repeat (5) cyc(1, 1'b0, 8'd0, 1'b0);
      drain(1);

      // Reset mid-word at sel=5, then a fresh word
      cyc(0, 1'b1, 8'h3C, 1'b1);
      repeat (5) cyc(0, 1'b0, 8'd0, 1'b1);
      chk("pre_reset_sel", 32'(sl[0]), 5);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset();
      m_active = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 1'b1, 8'h96, 1'b1);
      chk("restart_sel", 32'(sl[0]), 0);
      drain(0);

`ifdef MUX_SEL_PARITY_EN
      cyc(0, 1'b1, 8'h07, 1'b1);
      drain(0);
      cyc(0, 1'b1, 8'h03, 1'b1);
      drain(0);
`endif

      run_rand(0, 30);
      run_rand(1, 20);

      chk("exp_q_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
